mem_access_initiator: RTL and testbench
=======================================

MEM_ACCESS_INITIATOR -- requirements
Module: mem_access_initiator

Interface
REQ-001 The block SHALL have parameter READ_LATENCY, default 1, giving the cycles from the first cycle ram_address is presented to the cycle ram_data_out is valid; legal range 1..4.
REQ-002 The block SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid  in  1  request present.
REQ-005 The block SHALL have port req_ready  out  1  block can accept a request.
REQ-006 The block SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-007 The block SHALL have port req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-008 The block SHALL have port req_signed  in  1  sign-extend load result.
REQ-009 The block SHALL have port req_address  in  18  byte address.
REQ-010 The block SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-011 The block SHALL have port resp_valid  out  1  response present.
REQ-012 The block SHALL have port resp_ready  in  1  consumer accepts response.
REQ-013 The block SHALL have port resp_rdata  out  32  load result, 0 for stores and errors.
REQ-014 The block SHALL have port resp_error  out  1  request rejected; no memory access made.
REQ-015 The block SHALL have ports ram_address out 18, ram_data_in out 32, ram_byte_enablers out 4, ram_write_enable out 1, ram_data_out in 32, driving the team's 32-bit byte-addressable single-port RAM (the RAM rotates lanes by address[1:0] internally).

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, READ, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 On req_valid and req_ready in cycle T, the block SHALL register all req_* fields; the next state SHALL be RESP if the request is erroneous, else WRITE (store) or READ (load).
REQ-018 req_size 11 SHALL always be erroneous; erroneous requests SHALL drive no RAM access and SHALL respond with resp_error 1 and resp_rdata 0 in cycle T+1.
REQ-019 From cycle T+1 until the return to IDLE, ram_address SHALL equal the registered address; in IDLE it SHALL be 0.
REQ-020 ram_byte_enablers SHALL be 0001 for byte, 0011 for half and 1111 for word while in WRITE or READ, and 0000 otherwise.
REQ-021 ram_data_in SHALL equal the registered req_wdata unmodified; lane placement is done by the RAM.
REQ-022 WRITE SHALL last exactly one cycle (T+1), with ram_write_enable 1 only in that cycle; the block SHALL then enter RESP, giving resp_valid in T+2 with resp_rdata 0 and resp_error 0.
REQ-023 In READ, ram_write_enable SHALL be 0; a 3-bit counter SHALL hold READ for READ_LATENCY+1 cycles; ram_data_out SHALL be captured at the end of cycle T+1+READ_LATENCY; resp_valid SHALL assert in T+2+READ_LATENCY.
REQ-024 Load extension: byte uses ram_data_out[7:0], half uses [15:0], word uses [31:0]; if req_signed, the result SHALL be sign-extended from bit 7 or bit 15, otherwise zero-extended; req_signed SHALL be ignored for word.
REQ-025 In RESP, resp_valid, resp_rdata and resp_error SHALL hold stable until resp_ready is 1; on that edge the block SHALL return to IDLE.
REQ-026 req_valid during WRITE, READ or RESP SHALL be ignored (no capture), and a new request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-027 ram_write_enable SHALL never be 1 outside WRITE, including during reset.

Reset
REQ-028 While reset is 1 at a clock edge, the state SHALL become IDLE, the counter 0 and all registered fields 0; any in-flight access or pending response SHALL be discarded.
REQ-029 Reset output values: req_ready 1, resp_valid 0, resp_rdata 0, resp_error 0, ram_address 0, ram_data_in 0, ram_byte_enablers 0000, ram_write_enable 0.
REQ-030 reset SHALL take priority over every handshake in the same cycle.

Configuration
REQ-031 With macro MEM_ACCESS_ALIGN_CHECK_EN defined, a half at address[0]=1 or a word at address[1:0]!=00 SHALL be erroneous (handled per REQ-018).
REQ-032 Without MEM_ACCESS_ALIGN_CHECK_EN, misaligned half and word accesses SHALL be issued normally; only req_size 11 is erroneous.

Verification
REQ-033 Word store addr 0x00010, data 0xDEADBEEF -> one-cycle ram_write_enable at T+1 with enablers 1111; response at T+2 with rdata 0 and error 0.
REQ-034 Load signed byte addr 0x00013, RAM returns 0x00000080, READ_LATENCY=1 -> enablers 0001, resp_rdata 0xFFFFFF80 at T+3; same case unsigned -> 0x00000080.
REQ-035 Load half addr 0x00003 -> with MEM_ACCESS_ALIGN_CHECK_EN: resp_error 1 at T+1 and no RAM enable; without the macro: normal read and error 0.
REQ-036 resp_ready held 0 for 5 cycles with req_valid high throughout -> response stable, req_ready 0, no second access; acceptance only after the response handshake.
REQ-037 Reset asserted in cycle T+1 of a store -> ram_write_enable 0 from the next cycle, no response produced, req_ready 1.
REQ-038 READ_LATENCY=4, word load returns 0x12345678 -> data captured at end of T+5, resp_valid at T+6.

Source files
------------

// File: rtl/mem_access_initiator.sv
// Load/store initiator for a 32-bit byte-addressable single-port RAM with configurable read latency.
// Define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned half/word requests.
module mem_access_initiator #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [17:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [17:0] ram_address,
  output logic [31:0] ram_data_in,
  output logic [3:0]  ram_byte_enablers,
  output logic        ram_write_enable,
  input  logic [31:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [17:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;
  logic        error_q;
  logic [3:0]  be_q;
  logic        we_q;

  logic        req_err_d;
  logic [3:0]  be_d;
  logic [31:0] load_ext_d;

  always_comb begin
    req_err_d = (req_size == 2'b11);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    req_err_d = req_err_d
              | ((req_size == 2'b01) && req_address[0])
              | ((req_size == 2'b10) && (req_address[1:0] != 2'b00));
`endif
    case (req_size)
      2'b00:   be_d = 4'b0001;
      2'b01:   be_d = 4'b0011;
      2'b10:   be_d = 4'b1111;
      default: be_d = 4'b0000;
    endcase
  end

  // The RAM already rotated the addressed lane down to bit 0.
  always_comb begin
    case (size_q)
      2'b00:   load_ext_d = {{24{signed_q & ram_data_out[7]}}, ram_data_out[7:0]};
      2'b01:   load_ext_d = {{16{signed_q & ram_data_out[15]}}, ram_data_out[15:0]};
      default: load_ext_d = ram_data_out;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= 18'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      error_q      <= 1'b0;
      be_q         <= 4'b0000;
      we_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_q      <= req_size;
            signed_q    <= req_signed;
            addr_q      <= req_address;
            wdata_q     <= req_wdata;
            cnt_q       <= 3'd0;
            req_ready_q <= 1'b0;
            if (req_err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              error_q      <= 1'b1;
              rdata_q      <= 32'd0;
            end else begin
              state_q <= req_write ? WRITE : READ;
              be_q    <= be_d;
              we_q    <= req_write;
            end
          end
        end
        WRITE: begin
          we_q         <= 1'b0;
          be_q         <= 4'b0000;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          rdata_q      <= 32'd0;
          error_q      <= 1'b0;
        end
        READ: begin
          // Address has been held for READ_LATENCY cycles; data is valid now.
          if (cnt_q == 3'(READ_LATENCY)) begin
            be_q         <= 4'b0000;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= load_ext_d;
            error_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            error_q      <= 1'b0;
            addr_q       <= 18'd0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_rdata        = rdata_q;
  assign resp_error        = error_q;
  assign ram_address       = addr_q;
  assign ram_data_in       = wdata_q;
  assign ram_byte_enablers = be_q;
  assign ram_write_enable  = we_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench for mem_access_initiator: READ_LATENCY=1 instance for most cases,
// READ_LATENCY=4 instance for long-latency load timing.
module tb_mem_access_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_write, req_signed, resp_ready;
  logic [1:0]  req_size;
  logic [17:0] req_address;
  logic [31:0] req_wdata;
  logic        req_ready, resp_valid, resp_error, ram_we;
  logic [31:0] resp_rdata, ram_din, ram_dout;
  logic [17:0] ram_addr;
  logic [3:0]  ram_be;

  logic        req_valid4, resp_ready4;
  logic [17:0] req_address4;
  logic        req_ready4, resp_valid4, resp_error4, ram_we4;
  logic [31:0] resp_rdata4, ram_din4, ram_dout4;
  logic [17:0] ram_addr4;
  logic [3:0]  ram_be4;

  mem_access_initiator #(.READ_LATENCY(1)) u_dut (
    .clock(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ram_address(ram_addr), .ram_data_in(ram_din), .ram_byte_enablers(ram_be),
    .ram_write_enable(ram_we), .ram_data_out(ram_dout)
  );

  mem_access_initiator #(.READ_LATENCY(4)) u_dut4 (
    .clock(clk), .reset(reset),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_write(1'b0),
    .req_size(2'b10), .req_signed(1'b0), .req_address(req_address4),
    .req_wdata(32'd0), .resp_valid(resp_valid4), .resp_ready(resp_ready4),
    .resp_rdata(resp_rdata4), .resp_error(resp_error4),
    .ram_address(ram_addr4), .ram_data_in(ram_din4), .ram_byte_enablers(ram_be4),
    .ram_write_enable(ram_we4), .ram_data_out(ram_dout4)
  );

  // RAM models: return ram_ret only when a read was actually presented READ_LATENCY cycles earlier.
  logic [31:0] ram_ret, ram_ret4;
  logic [31:0] pipe1;
  logic [31:0] pipe4 [4];
  always @(posedge clk) pipe1 <= (ram_be != 4'b0 && !ram_we) ? ram_ret : 32'h0BAD0BAD;
  always @(posedge clk) begin
    pipe4[0] <= (ram_be4 != 4'b0 && !ram_we4) ? ram_ret4 : 32'h0BAD0BAD;
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign ram_dout  = pipe1;
  assign ram_dout4 = pipe4[3];

  int cyc = 0;
  int wr_count = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_we) wr_count <= wr_count + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int t0;
  int w0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [17:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_address = a; req_wdata = d;
    t0 = cyc;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic check_resp();
    exp_t e;
    wait_valid();
    chk("resp_seen", {31'd0, resp_valid}, 32'd1);
    e = sb.pop_front();
    chk("resp_latency", cyc - t0, e.lat);
    chk("resp_rdata", resp_rdata, e.rdata);
    chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("idle_ram_addr", {14'd0, ram_addr}, 32'd0);
  endtask

  task automatic do_load(input logic [1:0] sz, input logic sg, input logic [17:0] a,
                         input logic [31:0] ret, input logic [31:0] exp, input logic [3:0] be);
    ram_ret = ret;
    push(exp, 1'b0, 3);
    send(1'b0, sz, sg, a, 32'h0);
    chk("load_be", {28'd0, ram_be}, {28'd0, be});
    chk("load_we", {31'd0, ram_we}, 32'd0);
    chk("load_addr", {14'd0, ram_addr}, {14'd0, a});
    check_resp();
    $display("load size=%b signed=%b addr=%h ram=%h -> rdata=%h err=%b",
             sz, sg, a, ret, resp_rdata, resp_error);
    handshake();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_address = 18'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    req_valid4 = 1'b0; req_address4 = 18'd0; resp_ready4 = 1'b0;
    ram_ret = 32'd0; ram_ret4 = 32'd0;
    repeat (3) tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
    chk("rst_ram_addr", {14'd0, ram_addr}, 32'd0);
    chk("rst_ram_din", ram_din, 32'd0);
    chk("rst_ram_be", {28'd0, ram_be}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    reset = 1'b0;
    tick();

    // Word store
    w0 = wr_count;
    push(32'd0, 1'b0, 2);
    send(1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF);
    chk("st_we", {31'd0, ram_we}, 32'd1);
    chk("st_be", {28'd0, ram_be}, 32'hF);
    chk("st_addr", {14'd0, ram_addr}, 32'h10);
    chk("st_din", ram_din, 32'hDEADBEEF);
    chk("st_req_ready", {31'd0, req_ready}, 32'd0);
    check_resp();
    chk("st_we_after", {31'd0, ram_we}, 32'd0);
    chk("st_write_count", wr_count - w0, 32'd1);
    $display("store word addr=00010 data=deadbeef -> rdata=%h err=%b", resp_rdata, resp_error);
    handshake();

    // Loads: extension cases
    do_load(2'b00, 1'b1, 18'h00013, 32'h00000080, 32'hFFFFFF80, 4'b0001);
    do_load(2'b00, 1'b0, 18'h00013, 32'h00000080, 32'h00000080, 4'b0001);
    do_load(2'b01, 1'b1, 18'h00020, 32'h12348001, 32'hFFFF8001, 4'b0011);
    do_load(2'b01, 1'b0, 18'h00020, 32'h12348001, 32'h00008001, 4'b0011);
    do_load(2'b10, 1'b1, 18'h00024, 32'h80000001, 32'h80000001, 4'b1111);
    do_load(2'b00, 1'b1, 18'h00005, 32'hABCDEF7F, 32'h0000007F, 4'b0001);
    do_load(2'b00, 1'b0, 18'h00005, 32'hABCDEF12, 32'h00000012, 4'b0001);

    // Reserved size: error, no RAM access
    w0 = wr_count;
    push(32'd0, 1'b1, 1);
    send(1'b1, 2'b11, 1'b0, 18'h00040, 32'h00001234);
    chk("err_be", {28'd0, ram_be}, 32'd0);
    chk("err_we", {31'd0, ram_we}, 32'd0);
    check_resp();
    chk("err_write_count", wr_count - w0, 32'd0);
    $display("reserved size store addr=00040 -> rdata=%h err=%b", resp_rdata, resp_error);
    handshake();

    // Misaligned half
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    push(32'd0, 1'b1, 1);
    send(1'b0, 2'b01, 1'b0, 18'h00003, 32'h0);
    chk("mis_be", {28'd0, ram_be}, 32'd0);
`else
    ram_ret = 32'h0000C0DE;
    push(32'h0000C0DE, 1'b0, 3);
    send(1'b0, 2'b01, 1'b0, 18'h00003, 32'h0);
    chk("mis_be", {28'd0, ram_be}, 32'h3);
`endif
    check_resp();
    $display("misaligned half load addr=00003 -> rdata=%h err=%b", resp_rdata, resp_error);
    handshake();

    // Backpressure with req_valid held high; the held request is a store
    w0 = wr_count;
    ram_ret = 32'h5555AAAA;
    push(32'h5555AAAA, 1'b0, 3);
    send(1'b0, 2'b10, 1'b0, 18'h00030, 32'h0);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
    req_address = 18'h00044; req_wdata = 32'hCAFEF00D;
    check_resp();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_resp_rdata", resp_rdata, 32'h5555AAAA);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_ram_be", {28'd0, ram_be}, 32'd0);
    end
    chk("bp_no_write", wr_count - w0, 32'd0);
    $display("backpressured load addr=00030 -> rdata=%h err=%b", resp_rdata, resp_error);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_accept_ready", {31'd0, req_ready}, 32'd1);
    t0 = cyc;
    push(32'd0, 1'b0, 2);
    tick();
    req_valid = 1'b0;
    chk("bp_store_we", {31'd0, ram_we}, 32'd1);
    chk("bp_store_addr", {14'd0, ram_addr}, 32'h44);
    check_resp();
    $display("held store addr=00044 data=cafef00d -> rdata=%h err=%b", resp_rdata, resp_error);
    handshake();

    // Reset in the WRITE cycle of a store
    w0 = wr_count;
    send(1'b1, 2'b10, 1'b0, 18'h00050, 32'h11111111);
    chk("rst_st_we", {31'd0, ram_we}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_st_we_off", {31'd0, ram_we}, 32'd0);
    chk("rst_st_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_st_be", {28'd0, ram_be}, 32'd0);
    repeat (3) tick();
    chk("rst_st_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_st_write_count", wr_count - w0, 32'd1);
    $display("store addr=00050 interrupted by reset -> resp_valid=%b", resp_valid);

    // READ_LATENCY=4 word load
    begin
      int n;
      ram_ret4 = 32'h12345678;
      req_valid4 = 1'b1; req_address4 = 18'h00060;
      t0 = cyc;
      chk("rl4_req_ready", {31'd0, req_ready4}, 32'd1);
      tick();
      req_valid4 = 1'b0;
      n = 0;
      while (!resp_valid4 && n < 20) begin
        tick();
        n++;
      end
      chk("rl4_resp_seen", {31'd0, resp_valid4}, 32'd1);
      chk("rl4_latency", cyc - t0, 32'd6);
      chk("rl4_rdata", resp_rdata4, 32'h12345678);
      chk("rl4_error", {31'd0, resp_error4}, 32'd0);
      $display("rl4 word load addr=00060 -> rdata=%h err=%b", resp_rdata4, resp_error4);
      resp_ready4 = 1'b1;
      tick();
      resp_ready4 = 1'b0;
      chk("rl4_idle", {31'd0, req_ready4}, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
